core_scheduler: RTL
===================

// Module: core_scheduler
// PURPOSE
//  Per-core instruction sequencer. Drives core_state, which the fetcher, decoder, LSUs, ALUs and PC_NZP units consume.
//  Owns the shared current_pc. Commits lane 0's next_pc at UPDATE. Detects lane divergence.
//  Sits between the dispatcher (start/done) and the core datapath.
// PARAMETERS
//  THREADS  4  lanes per block
//  PC_W     8  program-counter width
//  TC_W     3  thread_count width (must hold THREADS)
// PORTS
//  clk                input   1             core clock
//  reset              input   1             synchronous, active-high
//  start              input   1             dispatcher launch pulse, sampled in IDLE only
//  thread_count       input   TC_W          active lanes for this block, latched on accepted start
//  fetcher_state      input   3             fetcher FSM; 3'b010 = FETCHED
//  decoded_mem_read   input   1             current instruction is LDR
//  decoded_mem_write  input   1             current instruction is STR
//  decoded_ret        input   1             current instruction is RET
//  lsu_state          input   2*THREADS     per-lane LSU state: 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
//  next_pc            input   PC_W*THREADS  per-lane next PC from PC_NZP, lane i at [i*PC_W +: PC_W]
//  core_state         output  3             sequencer state, encoding below
//  current_pc         output  PC_W          PC of the instruction in flight
//  active_mask        output  THREADS       bit i = 1 iff i < latched thread_count
//  done               output  1             block complete; held until reset
//  diverged           output  1             sticky; set when active lanes disagree on next_pc at UPDATE
// BEHAVIOUR
//  Reset (sync): core_state=IDLE, current_pc=0, active_mask=0, done=0, diverged=0, latched count=0.
//   Reset wins over all other inputs on the same edge. Reset mid-instruction aborts it; next cycle is IDLE.
//  State encoding: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
//  Transitions (all registered, one per clk edge):
//   IDLE    : start=1 latches min(thread_count,THREADS) and sets active_mask.
//             If latched count==0, go to DONE with done=1. Else go to FETCH.
//   FETCH   : hold until fetcher_state==3'b010, then go to DECODE.
//   DECODE  : go to REQUEST unconditionally. Decoded_* outputs are valid from here on.
//   REQUEST : go to WAIT unconditionally. LSUs launch here when decoded_mem_read|write is set.
//   WAIT    : hold while any active lane has lsu_state in {01,10}. Otherwise go to EXECUTE.
//             Inactive lanes are ignored.
//   EXECUTE : go to UPDATE unconditionally. ALUs compute and PC_NZP forms next_pc.
//   UPDATE  : if decoded_ret, go to DONE and set done=1; current_pc is unchanged.
//             Else current_pc <= next_pc[lane0] and go to FETCH.
//   DONE    : terminal. Hold until reset; start is ignored.
//  Divergence: in UPDATE with !decoded_ret, if any active lane's next_pc != lane0's, diverged<=1 (sticky).
//   Lane0's value is still committed.
//  start outside IDLE is ignored, and thread_count is not re-latched.
//  Minimum instruction latency is 6 cycles: FETCHED on the first FETCH cycle, LSUs idle.
//   Each extra FETCH or WAIT cycle adds 1.
//  current_pc wraps modulo 2^PC_W. No overflow flag.
//  Outputs are registered, with no combinational path from inputs to outputs.
// STRUCTURE
//  gpu_pkg: CORE_* state localparams (shared with PC_NZP, decoder, fetcher, LSU);
//   FETCHER_FETCHED=3'b010; LSU_IDLE/REQUESTING/WAITING/DONE encodings.
//  Sub-module lane_mask_gen (thread_count -> THREADS-bit thermometer mask, clamped), reused by the dispatcher.
//  Everything else lives in one always block for state/pc/flags plus comb next-state logic.
// TESTING
//  1 Reset: hold reset 2 cycles with start=1 -> core_state=000, current_pc=0, done=0, diverged=0, mask=0.
//  2 ALU instr: start, thread_count=4, FETCHED on cycle 1, LSUs 00, next_pc all 8'd1, ret=0
//    -> states 001,010,011,100,101,110,001; current_pc=1 after exactly 6 cycles.
//  3 LDR stall: lane2 lsu_state 01 for 2 cycles then 10 for 3 cycles then 11
//    -> WAIT held 5 cycles, EXECUTE on the next; lane3 at 01 with thread_count=3 does not stall.
//  4 Branch/divergence: next_pc lanes {9,9,9,9} -> current_pc=9, diverged=0.
//    Then lanes {4,5,4,4} -> current_pc=4, diverged=1 and stays 1 afterwards.
//  5 RET: decoded_ret=1 at UPDATE with current_pc=7 -> core_state=111, done=1, current_pc stays 7.
//    start pulses are ignored until reset.
//  6 Edge cases: thread_count=0 -> IDLE->DONE in 1 cycle. thread_count=7 -> mask=4'b1111.
//    Reset asserted in WAIT -> IDLE next edge, pc=0.

Source files
------------

// File: rtl/core_scheduler_pkg.sv
// Shared encodings for the core sequencer and the datapath units that decode core_state.
// Fetcher and LSU state codes live here so every consumer agrees on them.
package core_scheduler_pkg;

  typedef logic [2:0] core_state_t;

  localparam core_state_t CORE_IDLE    = 3'b000;
  localparam core_state_t CORE_FETCH   = 3'b001;
  localparam core_state_t CORE_DECODE  = 3'b010;
  localparam core_state_t CORE_REQUEST = 3'b011;
  localparam core_state_t CORE_WAIT    = 3'b100;
  localparam core_state_t CORE_EXECUTE = 3'b101;
  localparam core_state_t CORE_UPDATE  = 3'b110;
  localparam core_state_t CORE_DONE    = 3'b111;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // A lane holds the core in WAIT only while its memory access is outstanding.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// Bundle between the core sequencer and its dispatcher/datapath neighbours.
// slave is the sequencer's view; master is the surrounding core/dispatcher view.
interface core_scheduler_if #(
  parameter int THREADS = 4,
  parameter int PC_W    = 8,
  parameter int TC_W    = 3
);
  logic                    start;
  logic [TC_W-1:0]         thread_count;
  logic [2:0]              fetcher_state;
  logic                    decoded_mem_read;
  logic                    decoded_mem_write;
  logic                    decoded_ret;
  logic [2*THREADS-1:0]    lsu_state;
  logic [PC_W*THREADS-1:0] next_pc;
  logic [2:0]              core_state;
  logic [PC_W-1:0]         current_pc;
  logic [THREADS-1:0]      active_mask;
  logic                    done;
  logic                    diverged;

  modport slave (
    input  start, thread_count, fetcher_state, decoded_mem_read, decoded_mem_write,
           decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, active_mask, done, diverged
  );

  modport master (
    output start, thread_count, fetcher_state, decoded_mem_read, decoded_mem_write,
           decoded_ret, lsu_state, next_pc,
    input  core_state, current_pc, active_mask, done, diverged
  );
endinterface

// File: rtl/core_scheduler_lane_mask_gen.sv
// Thermometer mask of active lanes from a thread count; counts above THREADS saturate
// to all-ones, so the clamp falls out of the per-lane compare.
module lane_mask_gen #(
  parameter int THREADS = 4,
  parameter int TC_W    = 3
) (
  input  logic [TC_W-1:0]    thread_count_i,
  output logic [THREADS-1:0] mask_o
);

  for (genvar gi = 0; gi < THREADS; gi++) begin : g_lane
    localparam logic [TC_W:0] IDX = (TC_W + 1)'(gi);
    assign mask_o[gi] = ({1'b0, thread_count_i} > IDX);
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: steps FETCH..UPDATE, owns current_pc, commits lane 0's
// next_pc and flags lane divergence. All outputs come straight from registers.
module core_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_W    = 8,
  parameter int TC_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  core_scheduler_if.slave  bus
);
  import core_scheduler_pkg::*;

  core_state_t        state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [THREADS-1:0] mask_q, mask_d;
  logic               done_q, done_d;
  logic               div_q, div_d;

  logic [THREADS-1:0] start_mask;
  logic [THREADS-1:0] lane_busy;
  logic [THREADS-1:0] lane_diff;
  logic               unused_mem_flags;

  // Memory flags steer the LSUs directly; the sequencer only watches lsu_state.
  assign unused_mem_flags = bus.decoded_mem_read ^ bus.decoded_mem_write;

  lane_mask_gen #(
    .THREADS (THREADS),
    .TC_W    (TC_W)
  ) u_lane_mask_gen (
    .thread_count_i (bus.thread_count),
    .mask_o         (start_mask)
  );

  for (genvar gi = 0; gi < THREADS; gi++) begin : g_lane
    assign lane_busy[gi] = lsu_busy(bus.lsu_state[2*gi +: 2]);
    assign lane_diff[gi] = (bus.next_pc[gi*PC_W +: PC_W] != bus.next_pc[0 +: PC_W]);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    done_d  = done_q;
    div_d   = div_q;
    case (state_q)
      CORE_IDLE: begin
        if (bus.start) begin
          mask_d = start_mask;
          if (start_mask == '0) begin
            state_d = CORE_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CORE_FETCH;
          end
        end
      end
      CORE_FETCH: begin
        if (bus.fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
      end
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT: begin
        if ((lane_busy & mask_q) == '0) state_d = CORE_EXECUTE;
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        if (bus.decoded_ret) begin
          state_d = CORE_DONE;
          done_d  = 1'b1;
        end else begin
          // Lane 0 always wins; disagreement among active lanes is only flagged.
          pc_d    = bus.next_pc[0 +: PC_W];
          state_d = CORE_FETCH;
          if ((lane_diff & mask_q) != '0) div_d = 1'b1;
        end
      end
      CORE_DONE: state_d = CORE_DONE;
      default:   state_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CORE_IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      div_q   <= div_d;
    end
  end

  assign bus.core_state  = state_q;
  assign bus.current_pc  = pc_q;
  assign bus.active_mask = mask_q;
  assign bus.done        = done_q;
  assign bus.diverged    = div_q;

endmodule
